fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single FIFO write port between NUM_REQ requesters using round-robin, burst-locked grants.
//  - Sits in front of pointer_logic: drives its wr input and the write-data path of the FIFO memory.
//  - A granted requester streams up to BURST_MAX words before the grant rotates.
//  - Honours fifo_full, so no word is ever acknowledged that the FIFO does not take.
// PARAMETERS
//  NUM_REQ     4   number of requesters, >=2
//  DATA_WIDTH  8   word width
//  BURST_MAX   4   max accepted words per grant, >=1
// PORTS
//  clk        in   1                    rising-edge clock
//  rst_n      in   1                    asynchronous active-low reset
//  req        in   NUM_REQ              per-requester word-valid; held until acked
//  req_last   in   NUM_REQ              per-requester: current word ends its burst
//  req_data   in   NUM_REQ*DATA_WIDTH   requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//  fifo_full  in   1                    from FIFO flag logic
//  gnt        out  NUM_REQ              registered one-hot owner; all zero when idle
//  ack        out  NUM_REQ              word of requester i accepted this cycle
//  wr         out  1                    write strobe to pointer_logic
//  wr_data    out  DATA_WIDTH           muxed data of the owner
//  busy       out  1                    state == GRANT
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, gnt=0, beat_cnt=0.
//  - last_owner=NUM_REQ-1, so req[0] has top priority after reset.
//  - ack, wr and wr_data follow combinationally: ack=0, wr=0, wr_data=0.
//  Reset mid-burst aborts the burst. No word is written after rst_n falls.
//  FSM states: IDLE, GRANT.
//  - IDLE, |req=1: in the next cycle gnt=onehot(first set req scanning from last_owner+1 with wrap),
//    then go to GRANT.
//  - IDLE, |req=0: stay in IDLE.
//  Combinational outputs:
//  - ack = gnt & req & {NUM_REQ{~fifo_full}}; wr = |ack.
//  - wr_data = data of the gnt index; 0 when gnt=0.
//  - Latency: req rising in cycle N from IDLE gives the earliest ack in cycle N+1.
//  GRANT, per cycle, owner o:
//  - Accepted beat (ack[o]): beat_cnt++.
//    If req_last[o] or beat_cnt==BURST_MAX-1: release, i.e.
//    gnt<=0, last_owner<=o, beat_cnt<=0, state<=IDLE.
//  - req[o]=0: release the same way. No word is written.
//  - req[o]=1 and fifo_full=1: hold. No ack, beat_cnt unchanged, owner kept.
//  - Requests from non-owners are ignored until IDLE. Release always costs one idle cycle.
//  Arithmetic and width:
//  - beat_cnt is $clog2(BURST_MAX+1) bits and never exceeds BURST_MAX-1.
//  - The round-robin index wraps NUM_REQ-1 -> 0.
//  Boundary cases:
//  - BURST_MAX=1: release after every accepted word.
//  - fifo_full rises mid-burst: the burst stalls and is not preempted.
//  - Simultaneous req_last and the BURST_MAX limit: a single release.
//  - Requester protocol: req_data must stay stable while req=1 and ack=0.
// STRUCTURE
//  Shared package fifo_pkg:
//  - ARB_IDLE/ARB_GRANT localparams.
//  - clog2-based width constants, also used by pointer_logic sizing.
//  Sub-module rr_pick (combinational):
//  - inputs req vector and last_owner; outputs a one-hot pick and the pick index.
//  - Instantiated once.
// TESTING
//  1 Reset: rst_n=0 with req=4'b1111 -> gnt=0, wr=0, busy=0. After release, first gnt=4'b0001.
//  2 req=4'b1111, all req_last=0, fifo_full=0, BURST_MAX=4:
//    gnt 0001 for 4 acks, 1 idle cycle, then 0010, 0100, 1000, 0001.
//    Writes in order: 4 words each from requesters 0, 1, 2, 3.
//  3 Requester 2 alone, req_last on its 2nd word -> exactly 2 acks, then IDLE.
//    Next grant goes to requester 3 if it requests.
//  4 fifo_full=1 for 3 cycles after the 2nd beat of requester 1:
//    - no ack or wr in those cycles, gnt held;
//    - 2 more acks afterwards, 4 words total.
//  5 Owner drops req after 1 beat -> release, beat_cnt=0.
//    The waiting requester 3 is granted 2 cycles after the drop.
//  6 rst_n pulsed low mid-burst (beat_cnt=2):
//    - gnt=0 immediately;
//    - after release, req=4'b0100 gets gnt=0100 with a full BURST_MAX of acks.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the FIFO write-side logic.
//   - Default arbiter geometry (requesters, word width, burst length).
//   - ARB_IDLE / ARB_GRANT encodings and the arbiter state enum built on them.
//   - clog2-based width helpers, also used to size the FIFO pointer logic.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_MAX  = 4;
    localparam int DEF_FIFO_DEPTH = 16;

    // Pointer width for pointer_logic; one extra bit distinguishes full from empty.
    localparam int PTR_W = $clog2(DEF_FIFO_DEPTH) + 1;

    localparam logic ARB_IDLE  = 1'b0;
    localparam logic ARB_GRANT = 1'b1;

    typedef enum logic {
        ST_IDLE  = ARB_IDLE,
        ST_GRANT = ARB_GRANT
    } arb_state_e;

    // Width of an index into n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a beat counter that must be able to hold burst_max.
    function automatic int beat_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundle between the requesters (master side) and the FIFO write arbiter
// (slave side).
//   req        per-requester word valid, held until acked
//   req_last   per-requester: current word ends its burst
//   req_data   requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full  FIFO full flag
//   gnt        registered one-hot owner, zero when idle
//   ack        per-requester word accepted this cycle
//   wr         write strobe into the FIFO pointer logic
//   wr_data    owner's data word, zero when no owner
//   busy       arbiter is in its grant state
// -----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            ack;
    logic                          wr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          busy;

    modport master (
        output req, req_last, req_data, fifo_full,
        input  gnt, ack, wr, wr_data, busy
    );

    modport slave (
        input  req, req_last, req_data, fifo_full,
        output gnt, ack, wr, wr_data, busy
    );
endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: scans req_i starting one past
// last_owner_i, wrapping NUM_REQ-1 -> 0, and returns the first hit.
//   req_i         request vector
//   last_owner_i  index of the most recently served requester
//   pick_o        one-hot winner, zero when req_i is zero
//   pick_idx_o    binary index of the winner
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [NUM_REQ-1:0] pick_o,
    output logic [IDX_W-1:0]   pick_idx_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    // Rotating priority scan; the last owner itself is checked last.
    always_comb begin
        pick_o     = '0;
        pick_idx_o = '0;
        found      = 1'b0;
        idx        = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_owner_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                pick_o     = '0;
                pick_o[idx] = 1'b1;
                pick_idx_o = idx;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single FIFO write port among NUM_REQ requesters with round-robin,
// burst-locked grants. A grant lasts until the owner marks its last word,
// reaches BURST_MAX accepted words, or drops its request; each release costs
// one idle cycle. fifo_full stalls the owner without preempting it.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of fifo_wr_arbiter_if (requests in, grant/write out)
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_MAX  = DEF_BURST_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int BEAT_W = beat_width(BURST_MAX);

    arb_state_e           state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     last_owner_q, last_owner_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic                 release_s;

    logic [NUM_REQ-1:0]    pick;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    ack;
    logic [DATA_WIDTH-1:0] words [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i        (bus.req),
        .last_owner_i (last_owner_q),
        .pick_o       (pick),
        .pick_idx_o   (pick_idx)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // gnt is zero outside GRANT, so ack can never fire while idle or in reset.
    assign ack      = gnt_q & bus.req & {NUM_REQ{~bus.fifo_full}};
    assign bus.ack  = ack;
    assign bus.wr   = |ack;
    assign bus.gnt  = gnt_q;
    assign bus.busy = (state_q == ST_GRANT);

    // Write data follows the owner; forced to zero with no owner.
    always_comb begin
        bus.wr_data = '0;
        if (|gnt_q) begin
            bus.wr_data = words[owner_q];
        end else begin
            bus.wr_data = '0;
        end
    end

    // Next-state: pick an owner from IDLE, count beats and decide release in GRANT.
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        release_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    state_d = ST_GRANT;
                    gnt_d   = pick;
                    owner_d = pick_idx;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (ack[owner_q]) begin
                    // req_last and the burst limit together still give one release.
                    if (bus.req_last[owner_q] || (beat_q == BEAT_W'(BURST_MAX - 1))) begin
                        release_s = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end else if (!bus.req[owner_q]) begin
                    release_s = 1'b1;
                end else begin
                    // FIFO full: owner keeps the grant, count unchanged.
                    beat_d = beat_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                beat_d  = '0;
            end
        endcase
        if (release_s) begin
            state_d      = ST_IDLE;
            gnt_d        = '0;
            last_owner_d = owner_q;
            beat_d       = '0;
        end else begin
            last_owner_d = last_owner_d;
        end
    end

    // State registers; last_owner resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed, table-driven bench for fifo_wr_arbiter (BURST_MAX=4) plus a second
// instance with BURST_MAX=1 sharing the same request inputs. Each table row is
// one clock cycle: inputs driven just after the rising edge, outputs compared
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;
    import fifo_pkg::*;

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic [3:0] gnt;
        logic [3:0] ack;
        logic       busy;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run  = 0;
    int   tests_fail = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus  ();
    fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus1 ();

    assign bus1.req       = bus.req;
    assign bus1.req_last  = bus.req_last;
    assign bus1.req_data  = bus.req_data;
    assign bus1.fifo_full = bus.fifo_full;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] last, input logic full,
                                input logic [3:0] gnt, input logic [3:0] ack, input logic busy);
        vec_t v;
        v.req = req; v.last = last; v.full = full;
        v.gnt = gnt; v.ack = ack; v.busy = busy;
        return v;
    endfunction

    function automatic logic [7:0] exp_data(input logic [3:0] g);
        case (g)
            4'b0001: return 8'h10;
            4'b0010: return 8'h21;
            4'b0100: return 8'h32;
            4'b1000: return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Assert reset with all requesters active; outputs must drop at once.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.req       = 4'b1111;
        bus.req_last  = 4'b0000;
        bus.fifo_full = 1'b0;
        #1;
        check({tag, " rst gnt"},  {4'b0, bus.gnt}, 8'h00);
        check({tag, " rst ack"},  {4'b0, bus.ack}, 8'h00);
        check({tag, " rst wr"},   {7'b0, bus.wr},  8'h00);
        check({tag, " rst busy"}, {7'b0, bus.busy}, 8'h00);
        check({tag, " rst data"}, bus.wr_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.req = 4'b0000;
    endtask

    task automatic run_rows(input string tag);
        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk);
            #1;
            bus.req       = vq[k].req;
            bus.req_last  = vq[k].last;
            bus.fifo_full = vq[k].full;
            @(negedge clk);
            check($sformatf("%s[%0d] gnt", tag, k),  {4'b0, bus.gnt},  {4'b0, vq[k].gnt});
            check($sformatf("%s[%0d] ack", tag, k),  {4'b0, bus.ack},  {4'b0, vq[k].ack});
            check($sformatf("%s[%0d] wr", tag, k),   {7'b0, bus.wr},   {7'b0, |vq[k].ack});
            check($sformatf("%s[%0d] data", tag, k), bus.wr_data,      exp_data(vq[k].gnt));
            check($sformatf("%s[%0d] busy", tag, k), {7'b0, bus.busy}, {7'b0, vq[k].busy});
        end
        vq.delete();
    endtask

    initial begin
        logic [3:0] oh;
        logic [3:0] exp1 [6];
        bus.req_data  = {8'h43, 8'h32, 8'h21, 8'h10};
        bus.req       = 4'b0000;
        bus.req_last  = 4'b0000;
        bus.fifo_full = 1'b0;

        // Reset, then full round-robin of 4-word bursts with one idle cycle between.
        do_reset("t1");
        vq.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        for (int r = 0; r < 4; r++) begin
            oh = 4'b0001 << r;
            for (int b = 0; b < 4; b++) begin
                vq.push_back(mk(4'b1111, 4'b0000, 1'b0, oh, oh, 1'b1));
            end
            vq.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        end
        vq.push_back(mk(4'b1111, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1));
        run_rows("t2");

        // Requester 2 alone, last on its 2nd word; requester 3 is next in line.
        do_reset("t3");
        vq.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vq.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1));
        vq.push_back(mk(4'b0100, 4'b0100, 1'b0, 4'b0100, 4'b0100, 1'b1));
        vq.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vq.push_back(mk(4'b1001, 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b1));
        vq.push_back(mk(4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        run_rows("t3");

        // FIFO full for 3 cycles after requester 1's 2nd beat: stall, no preemption.
        do_reset("t4");
        vq.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vq.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1));
        vq.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1));
        for (int s = 0; s < 3; s++) begin
            vq.push_back(mk(4'b1011, 4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b1));
        end
        vq.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1));
        vq.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b1));
        vq.push_back(mk(4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        run_rows("t4");

        // Owner 0 drops req after 1 beat; waiting requester 3 granted 2 cycles later
        // and then gets a full 4-word burst.
        do_reset("t5");
        vq.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vq.push_back(mk(4'b1001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1));
        vq.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1));
        vq.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        for (int b = 0; b < 4; b++) begin
            vq.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b1000, 4'b1000, 1'b1));
        end
        vq.push_back(mk(4'b1000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        run_rows("t5");

        // Reset at beat_cnt=2 aborts the burst; requester 2 then gets a full burst.
        do_reset("t6a");
        vq.push_back(mk(4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        vq.push_back(mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1));
        vq.push_back(mk(4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0001, 1'b1));
        run_rows("t6a");
        do_reset("t6mid");
        vq.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        for (int b = 0; b < 4; b++) begin
            vq.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1));
        end
        vq.push_back(mk(4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0));
        run_rows("t6b");

        // BURST_MAX=1 instance: one word per grant, idle cycle between grants.
        do_reset("t7");
        exp1 = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100};
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            bus.req       = 4'b1111;
            bus.req_last  = 4'b0000;
            bus.fifo_full = 1'b0;
            @(negedge clk);
            check($sformatf("t7[%0d] gnt1", k), {4'b0, bus1.gnt}, {4'b0, exp1[k]});
            check($sformatf("t7[%0d] ack1", k), {4'b0, bus1.ack}, {4'b0, exp1[k]});
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end

endmodule
